// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (binary16 by default) with
// round-to-nearest-even, special-value handling and a valid/ready stream.
module fp_addsub_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in_a,
    input  logic [EXP_W+MAN_W:0]   in_b,
    input  logic                   in_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_res,
    output logic [2:0]             out_flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 1;
    localparam int XW  = MAN_W + 3;
    localparam int AW  = MAN_W + 4;
    localparam int LZW = $clog2(AW + 1);
    localparam logic [EXP_W-1:0] E_ONES = '1;
    localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(XW);
    localparam logic [W-1:0]     QNAN   = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic       w_en;
    logic [2:0] r_vld_pipe;

    assign w_en      = !r_vld_pipe[2] | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_vld_pipe[2];

    // ---------------- S1: unpack, classify, swap, align ----------------
    logic             w_sa, w_sb;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic             w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [W-2:0]     w_ma, w_mb, w_big_m, w_sml_m;
    logic             w_swap, w_big_s, w_sml_s;
    logic [EXP_W-1:0] w_big_e, w_sml_e, w_d, w_dc;
    logic [SW-1:0]    w_big_sig, w_sml_sig;
    logic [2*XW-1:0]  w_sh;
    logic [AW-1:0]    w_sml_al;
    logic             w_spec;
    logic [W-1:0]     w_spec_res;
    logic [2:0]       w_spec_flags;

    assign w_sa = in_a[W-1];
    assign w_sb = in_b[W-1] ^ in_sub;
    assign w_ea = in_a[W-2:MAN_W];
    assign w_eb = in_b[W-2:MAN_W];
    assign w_fa = in_a[MAN_W-1:0];
    assign w_fb = in_b[MAN_W-1:0];

    assign w_a_nan  = (w_ea == E_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == E_ONES) && (w_fb != '0);
    assign w_a_snan = w_a_nan && !w_fa[MAN_W-1];
    assign w_b_snan = w_b_nan && !w_fb[MAN_W-1];
    assign w_a_inf  = (w_ea == E_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == E_ONES) && (w_fb == '0);
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);

    // Subnormals collapse to zero magnitude before the compare/swap
    assign w_ma    = w_a_zero ? '0 : in_a[W-2:0];
    assign w_mb    = w_b_zero ? '0 : in_b[W-2:0];
    assign w_swap  = w_mb > w_ma;
    assign w_big_m = w_swap ? w_mb : w_ma;
    assign w_sml_m = w_swap ? w_ma : w_mb;
    assign w_big_s = w_swap ? w_sb : w_sa;
    assign w_sml_s = w_swap ? w_sa : w_sb;
    assign w_big_e = w_big_m[W-2:MAN_W];
    assign w_sml_e = w_sml_m[W-2:MAN_W];
    assign w_big_sig = {(w_big_e != '0), w_big_m[MAN_W-1:0]};
    assign w_sml_sig = {(w_sml_e != '0), w_sml_m[MAN_W-1:0]};

    // Clamped shift: beyond XW every bit lands in the lower half and feeds sticky
    assign w_d      = w_big_e - w_sml_e;
    assign w_dc     = (w_d > SH_MAX) ? SH_MAX : w_d;
    assign w_sh     = {w_sml_sig, 2'b00, {XW{1'b0}}} >> w_dc;
    assign w_sml_al = {w_sh[2*XW-1:XW], |w_sh[XW-1:0]};

    always_comb begin
        w_spec       = 1'b0;
        w_spec_res   = '0;
        w_spec_flags = 3'b000;
        if (w_a_nan || w_b_nan) begin
            w_spec       = 1'b1;
            w_spec_res   = QNAN;
            w_spec_flags = {w_a_snan | w_b_snan, 2'b00};
        end else if (w_a_inf && w_b_inf && (w_sa != w_sb)) begin
            w_spec       = 1'b1;
            w_spec_res   = QNAN;
            w_spec_flags = 3'b100;
        end else if (w_a_inf) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sa, E_ONES, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sb, E_ONES, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_spec     = 1'b1;
            w_spec_res = {w_sa & w_sb, {(W-1){1'b0}}};
        end
    end

    logic             r1_sign, r1_eff_sub, r1_spec;
    logic [EXP_W-1:0] r1_exp;
    logic [AW-1:0]    r1_big, r1_sml;
    logic [W-1:0]     r1_spec_res;
    logic [2:0]       r1_spec_flags;

    // ---------------- S2: significand add/subtract ----------------
    logic [AW:0]      w_sum;
    assign w_sum = r1_eff_sub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                              : ({1'b0, r1_big} + {1'b0, r1_sml});

    logic             r2_sign, r2_spec;
    logic [EXP_W-1:0] r2_exp;
    logic [AW:0]      r2_sum;
    logic [W-1:0]     r2_spec_res;
    logic [2:0]       r2_spec_flags;

    // ---------------- S3: normalise, round, pack ----------------
    logic             w_carry, w_g, w_r, w_s, w_inc, w_ovf;
    logic [LZW-1:0]   w_lzc;
    logic [AW-1:0]    w_norm;
    logic [EXP_W+1:0] w_e, w_ef;
    logic [SW:0]      w_rnd;
    logic [W-1:0]     w_res;
    logic [2:0]       w_flags;

    assign w_carry = r2_sum[AW];

    always_comb begin
        w_lzc = LZW'(AW);
        for (int i = 0; i < AW; i++)
            if (r2_sum[i]) w_lzc = LZW'(AW - 1 - i);
    end

    // Carry: shift right once and keep the dropped bit alive in sticky
    assign w_norm = w_carry ? {r2_sum[AW:2], r2_sum[1] | r2_sum[0]}
                            : (r2_sum[AW-1:0] << w_lzc);
    assign w_e    = w_carry ? ({2'b00, r2_exp} + (EXP_W+2)'(1))
                            : ({2'b00, r2_exp} - (EXP_W+2)'(w_lzc));
    assign w_g    = w_norm[2];
    assign w_r    = w_norm[1];
    assign w_s    = w_norm[0];
    assign w_inc  = w_g & (w_r | w_s | w_norm[3]);
    assign w_rnd  = {1'b0, w_norm[AW-1:3]} + (SW+1)'(w_inc);
    assign w_ovf  = w_rnd[SW];
    assign w_ef   = w_e + (EXP_W+2)'(w_ovf);

    always_comb begin
        w_res   = {r2_sign, w_ef[EXP_W-1:0], w_rnd[MAN_W-1:0]};
        w_flags = {2'b00, w_g | w_r | w_s};
        if (r2_spec) begin
            w_res   = r2_spec_res;
            w_flags = r2_spec_flags;
        end else if (r2_sum == '0) begin
            w_res   = '0;
            w_flags = 3'b000;
        end else if (w_ef[EXP_W+1] || (w_ef == '0)) begin
            w_res   = {r2_sign, {(W-1){1'b0}}};
            w_flags = 3'b001;
        end else if (w_ef >= {2'b00, E_ONES}) begin
            w_res   = {r2_sign, E_ONES, {MAN_W{1'b0}}};
            w_flags = 3'b011;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe    <= '0;
            r1_sign       <= 1'b0;
            r1_eff_sub    <= 1'b0;
            r1_spec       <= 1'b0;
            r1_exp        <= '0;
            r1_big        <= '0;
            r1_sml        <= '0;
            r1_spec_res   <= '0;
            r1_spec_flags <= '0;
            r2_sign       <= 1'b0;
            r2_spec       <= 1'b0;
            r2_exp        <= '0;
            r2_sum        <= '0;
            r2_spec_res   <= '0;
            r2_spec_flags <= '0;
            out_res       <= '0;
            out_flags     <= '0;
        end else if (w_en) begin
            r_vld_pipe    <= {r_vld_pipe[1:0], in_valid};
            r1_sign       <= w_big_s;
            r1_eff_sub    <= w_big_s ^ w_sml_s;
            r1_spec       <= w_spec;
            r1_exp        <= w_big_e;
            r1_big        <= {w_big_sig, 3'b000};
            r1_sml        <= w_sml_al;
            r1_spec_res   <= w_spec_res;
            r1_spec_flags <= w_spec_flags;
            r2_sign       <= r1_sign;
            r2_spec       <= r1_spec;
            r2_exp        <= r1_exp;
            r2_sum        <= w_sum;
            r2_spec_res   <= r1_spec_res;
            r2_spec_flags <= r1_spec_flags;
            out_res       <= w_res;
            out_flags     <= w_flags;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for the binary16 adder/subtractor: latency, rounding,
// specials, backpressure ordering and asynchronous reset.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_ready, out_valid;
    logic [15:0] out_res;
    logic [2:0]  out_flags;

    int n_vec = 0;
    int n_err = 0;

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated operation: out_valid must rise exactly three cycles after accept
    task automatic single(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] er, input logic [2:0] ef, input string tag);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_res"}, 32'(out_res), 32'(er));
        chk({tag, "_flags"}, 32'(out_flags), 32'(ef));
    endtask

    logic [15:0] st_a [8];
    logic [15:0] st_r [8];
    logic [15:0] held;
    logic        stall_prev;
    int          sent, recv;

    initial begin
        st_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
        st_r = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};

        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(out_res), 32'd0);
        chk("rst_flags", 32'(out_flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        single(16'h3C00, 16'h4000, 1'b0, 16'h4200, 3'b000, "one_plus_two");
        single(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3'b000, "one_minus_one");
        single(16'h8000, 16'h8000, 1'b0, 16'h8000, 3'b000, "negzero_sum");
        single(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 3'b001, "tie_even_down");
        single(16'h3C00, 16'h1400, 1'b0, 16'h3C01, 3'b000, "exact_ulp");
        single(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 3'b001, "tie_odd_up");
        single(16'h3FFF, 16'h1000, 1'b0, 16'h4000, 3'b001, "round_renorm");
        single(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 3'b001, "far_sticky");
        single(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 3'b011, "overflow");
        single(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 3'b100, "inf_minus_inf");
        single(16'h4200, 16'h3C00, 1'b1, 16'h4000, 3'b000, "three_minus_one");
        single(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 3'b000, "neg_result");
        single(16'h7D00, 16'h3C00, 1'b0, 16'h7E00, 3'b100, "snan");
        single(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 3'b000, "qnan");
        single(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 3'b000, "inf_plus_fin");
        single(16'h3C00, 16'h7C00, 1'b1, 16'hFC00, 3'b000, "fin_minus_inf");
        single(16'h0001, 16'h0001, 1'b0, 16'h0000, 3'b000, "subnorm_flush");
        single(16'h0400, 16'h0401, 1'b1, 16'h8000, 3'b001, "underflow");

        // Back-to-back stream with the consumer stalled for cycles 4-8
        sent = 0; recv = 0; stall_prev = 1'b0; held = '0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge clk);
            out_ready = !(c >= 4 && c <= 8);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_a = st_a[sent]; in_b = 16'h3C00; in_sub = 1'b0;
            end
            #1;
            if (stall_prev) chk("stall_hold", 32'(out_res), 32'(held));
            if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                chk($sformatf("stream_%0d", recv), 32'(out_res), 32'(st_r[recv]));
                recv++;
            end
            if (in_valid && in_ready) sent++;
            stall_prev = out_valid && !out_ready;
            held = out_res;
        end
        chk("stream_recv", 32'(recv), 32'd8);
        chk("stream_sent", 32'(sent), 32'd8);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stream_no_dup", 32'(out_valid), 32'd0);
        end

        // Reset with operations in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_a = st_a[k]; in_b = 16'h3C00; in_sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_res", 32'(out_res), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
